// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters and returns each result, tagged with its requester ID, through a one-entry response register.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [31:0]       alu_rs1_data,
  output logic [31:0]       alu_input2,
  output logic [3:0]        alu_aluop,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters keep req_valid independent of req_ready.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_err_q, rsp_err_d;

  logic           slot_free;
  logic           found;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand_idx;
  logic           op_ok;

`ifdef ALU_ARB_RR_EN
  logic [IDW-1:0] last_q, last_d;
`endif

  assign slot_free = (state_q == EMPTY) || rsp_ready;

  // Search starts just after the last winner in round-robin mode and at index 0 otherwise.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_RR_EN
      cand_idx = IDW'((int'(last_q) + 1 + k) % NREQ);
`else
      cand_idx = IDW'(k);
`endif
      if (!found && req_valid[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_vld = slot_free && found;

  always_comb begin
    req_ready    = '0;
    alu_rs1_data = '0;
    alu_input2   = '0;
    alu_aluop    = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        alu_rs1_data = req_a[32*i +: 32];
        alu_input2   = req_b[32*i +: 32];
        alu_aluop    = req_op[4*i +: 4];
      end
    end
  end

  assign op_ok = (alu_aluop <= 4'b0110) ||
                 ((alu_aluop >= 4'b1010) && (alu_aluop <= 4'b1100));

  // A grant reloads the register even while the old response is being drained.
  always_comb begin
    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    if (grant_vld) begin
      state_d  = FULL;
      rsp_id_d = grant_idx;
      if (op_ok) begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d = '0;
        rsp_zero_d   = 1'b1;
        rsp_err_d    = 1'b1;
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  assign last_d = grant_vld ? grant_idx : last_q;

  // Resetting to NREQ-1 gives requester 0 first turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable({rsp_id, rsp_result, rsp_zero, rsp_err})));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a stand-in ALU, a driver that pushes expected responses, and a monitor that pops them on each handshake.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic [31:0]       alu_rs1_data;
  logic [31:0]       alu_input2;
  logic [3:0]        alu_aluop;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  int total = 0;
  int bad   = 0;
  // {id[1:0], result[31:0], zero, err}
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;

  // Operand table for the all-requesters traffic, with hand-computed results.
  logic [3:0]  op_tab  [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100};
  logic [31:0] a_tab   [4] = '{32'd1, 32'd10, 32'hF0, 32'hFF};
  logic [31:0] b_tab   [4] = '{32'd2, 32'd3, 32'h3C, 32'h0F};
  logic [31:0] res_tab [4] = '{32'd3, 32'd7, 32'h30, 32'hF0};

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_rs1_data (alu_rs1_data),
    .alu_input2   (alu_input2),
    .alu_aluop    (alu_aluop),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  // Stand-in ALU; undefined opcodes give a junk value the arbiter must ignore.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      4'b1010: return {31'd0, $signed(a) < $signed(b)};
      4'b1011: return {31'd0, a < b};
      4'b1100: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_model(alu_aluop, alu_rs1_data, alu_input2);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_op[4*i +: 4]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [31:0] res, input logic z,
                          input logic e);
    exp_q.push_back({id, res, z, e});
  endtask

  task automatic drain_wait();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic all_valid();
    for (int i = 0; i < NREQ; i++) set_req(i, op_tab[i], a_tab[i], b_tab[i]);
  endtask

  // Monitor: every completed response handshake is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id %0d with no expected entry at %0t", rsp_id, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e[35:34]));
        chk("rsp_result", rsp_result, mon_e[33:2]);
        chk("rsp_zero", 32'(rsp_zero), 32'(mon_e[1]));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset and idle
    #3;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_zero", 32'(rsp_zero), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    settle();
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_req_ready", 32'(req_ready), 0);
    chk("idle_alu_a", alu_rs1_data, 0);
    chk("idle_alu_b", alu_input2, 0);
    chk("idle_alu_op", 32'(alu_aluop), 0);

    // Single add from requester 1
    step();
    set_req(1, 4'b0000, 32'd5, 32'd7);
    settle();
    chk("add_req_ready", 32'(req_ready), 32'b0010);
    chk("add_alu_a", alu_rs1_data, 32'd5);
    chk("add_alu_b", alu_input2, 32'd7);
    chk("add_alu_op", 32'(alu_aluop), 0);
    push_exp(2'd1, 32'd12, 1'b0, 1'b0);
    step();
    req_valid = '0;
    settle();
    chk("add_latency_valid", 32'(rsp_valid), 1);
    step();
    settle();
    chk("add_drained", 32'(rsp_valid), 0);

    // All requesters valid every cycle
    do_reset();
    all_valid();
    for (int i = 0; i < 6; i++) begin
      settle();
`ifdef ALU_ARB_RR_EN
      g = i % NREQ;
`else
      g = 0;
`endif
      chk("arb_req_ready", 32'(req_ready), 32'(1) << g);
      chk("arb_alu_op", 32'(alu_aluop), 32'(op_tab[g]));
      push_exp(2'(g), res_tab[g], 1'b0, 1'b0);
      step();
    end
    req_valid = '0;
    drain_wait();

    // Unsupported opcode under backpressure, then same-cycle regrant
    set_req(2, 4'b0111, 32'd3, 32'd4);
    settle();
    chk("bad_op_req_ready", 32'(req_ready), 32'b0100);
    push_exp(2'd2, 32'd0, 1'b1, 1'b1);
    step();
    req_valid = '0;
    set_req(3, 4'b0010, 32'hFF, 32'h0F);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_id", 32'(rsp_id), 2);
      chk("bp_rsp_result", rsp_result, 0);
      chk("bp_rsp_zero", 32'(rsp_zero), 1);
      chk("bp_rsp_err", 32'(rsp_err), 1);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    chk("bp_regrant", 32'(req_ready), 32'b1000);
    push_exp(2'd3, 32'h0F, 1'b0, 1'b0);
    step();
    req_valid = '0;
    drain_wait();

    // Subtraction to zero, then asynchronous reset while the response is held
    set_req(0, 4'b0001, 32'd9, 32'd9);
    settle();
    chk("sub_req_ready", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 32'd0, 1'b1, 1'b0);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    settle();
    chk("sub_rsp_valid", 32'(rsp_valid), 1);
    chk("sub_rsp_zero", 32'(rsp_zero), 1);
    chk("sub_rsp_result", rsp_result, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(rsp_valid), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    all_valid();
    settle();
    chk("post_reset_first", 32'(req_ready), 32'b0001);
    push_exp(2'd0, res_tab[0], 1'b0, 1'b0);
    step();
    settle();
`ifdef ALU_ARB_RR_EN
    g = 1;
`else
    g = 0;
`endif
    chk("post_reset_second", 32'(req_ready), 32'(1) << g);
    push_exp(2'(g), res_tab[g], 1'b0, 1'b0);
    step();
    req_valid = '0;
    drain_wait();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational `alu` instance among `NREQ` requesters, such as the execute stage, the address-generation unit and the debug/CSR path.
- Each cycle it picks one valid requester, drives that requester's operands and opcode onto the ALU, and captures the result into a one-entry response register.
- The response is returned with the requester's ID under a valid/ready handshake.
- The block sits between the requesters and the `alu`, whose ports it drives directly.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant/accept; at most one bit set.
- `req_a`  in  NREQ*32  packed operand A; requester i is at `[32*i +: 32]`.
- `req_b`  in  NREQ*32  packed operand B.
- `req_op`  in  NREQ*4  packed aluop.
- `alu_rs1_data`  out  32  to the ALU `rs1_data` input.
- `alu_input2`  out  32  to the ALU `alu_input2` input.
- `alu_aluop`  out  4  to the ALU `aluop` input.
- `alu_result`  in  32  from the ALU `aluresult` output.
- `alu_zero`  in  1  from the ALU `zero` output.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that produced the response.
- `rsp_result`  out  32  captured ALU result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_err`  out  1  request used an unsupported opcode.

## Operation
Supported opcodes:
- Supported: 0000–0110 and 1010–1100.
- All other opcodes are unsupported.

Free slot (`slot_free`):
- `slot_free = !rsp_valid || rsp_ready`.

Grant:
- Grant is combinational.
- If `slot_free` and any `req_valid` bit is set, exactly one index g is selected and `req_ready[g]=1`.
- All other `req_ready` bits are 0.
- `req_ready` is 0 everywhere when `slot_free=0`.
- Requesters must not derive `req_valid` from `req_ready`.

ALU drive:
- When a grant is made: `alu_rs1_data=req_a[g]`, `alu_input2=req_b[g]`, `alu_aluop=req_op[g]`.
- With no grant, the ALU inputs are driven to 0, 0 and 4'b0000. No latching.

Capture on the clock edge that completes a grant:
- `rsp_valid` ← 1 and `rsp_id` ← g.
- Supported opcode: `rsp_result` ← `alu_result`, `rsp_zero` ← `alu_zero`, `rsp_err` ← 0.
- Unsupported opcode: `rsp_result` ← 0, `rsp_zero` ← 1, `rsp_err` ← 1; the ALU output is ignored.

Drain:
- If `rsp_valid && rsp_ready` and there is no new grant, `rsp_valid` ← 0.
- The data fields keep their last values.

Response-register state machine, two states:
- EMPTY (`rsp_valid=0`): on a grant, go to FULL; otherwise stay.
- FULL (`rsp_valid=1`):
  - `rsp_ready=0`: stay and hold all response fields stable.
  - `rsp_ready=1` with a new grant: stay in FULL and load the new response.
  - `rsp_ready=1` with no grant: go to EMPTY.

Priority pointer `last` (IDW bits):
- Updates to g only on a completed grant.

## Timing
Reset values:
- `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_zero=0`, `rsp_err=0`.
- `last=NREQ-1`, so requester 0 has top priority first.
- The combinational outputs follow from these.

Latency and throughput:
- A request accepted at edge N is visible on `rsp_*` after edge N: one cycle.
- Sustained throughput is one response per cycle while `rsp_ready=1`.

Backpressure:
- With `rsp_ready=0` and `rsp_valid=1`, no grant is made and all `req_ready` bits are 0.
- The response fields are held bit-stable.

Reset mid-operation:
- Asserting `rst_n=0` clears `rsp_valid` immediately, without waiting for a clock edge.
- A pending response is dropped and the pointer returns to its reset value.

Single requester:
- A single requester that is continuously valid is granted every cycle.

## Configuration
Macro `ALU_ARB_RR_EN`:
- Defined: round-robin. The search starts at `(last+1) mod NREQ` and wraps; the first valid index wins.
- Undefined: fixed priority. The lowest valid index always wins; `last` is not implemented and is tied to 0.

## Test plan
- Reset and idle:
  - Stimulus: reset asserted, then released with all `req_valid=0`.
  - Required: `rsp_valid=0` and `req_ready=0`; ALU inputs are 0/0/0000.
- Single add:
  - Stimulus: requester 1 sends op=0000, a=5, b=7.
  - Required: `req_ready[1]` high that cycle; next cycle `rsp_valid=1`, `rsp_id=1`, `rsp_result=12`, `rsp_zero=0`, `rsp_err=0`.
- Round-robin (`ALU_ARB_RR_EN` defined):
  - Stimulus: all 4 requesters valid every cycle with `rsp_ready=1`.
  - Required: grant order 0,1,2,3,0,1.
- Fixed priority (macro undefined):
  - Stimulus: same traffic as the round-robin test.
  - Required: requester 0 is granted every cycle.
- Backpressure and unsupported opcode:
  - Stimulus: requester 2 sends op=0111, and `rsp_ready` is held at 0 for 3 cycles.
  - Required: response is `rsp_err=1`, `rsp_result=0`, `rsp_zero=1`, stable for those 3 cycles, with `req_ready` all 0.
  - Required: when `rsp_ready` goes to 1, the next waiting request is granted in that same cycle.
- Subtraction and reset mid-operation:
  - Stimulus: requester 0 sends op=0001, a=9, b=9.
  - Required: `rsp_zero=1`, `rsp_result=0`.
  - Stimulus: pulse `rst_n=0` asynchronously while `rsp_valid=1`.
  - Required: `rsp_valid` drops to 0 before the next clock edge.
